// File: rtl/dram_line_pkg.sv
// Shared definitions for the DRAM line responder: line geometry, FSM and
// command encodings, and the lane-to-line byte-enable helper.
package dram_line_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LANE_BYTES = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  // Place the active-low lane mask, inverted to active-high enables, onto the
  // 16 byte enables of a line at lane position 'lane'.
  function automatic logic [LINE_BYTES-1:0] lane_byte_en(
    input logic [1:0]            lane,
    input logic [LANE_BYTES-1:0] mask_n
  );
    logic [LINE_BYTES-1:0] en;
    en = {{(LINE_BYTES - LANE_BYTES){1'b0}}, ~mask_n};
    return en << {lane, 2'b00};
  endfunction

endpackage

// File: rtl/dram_line_store.sv
// Single-port line store: 2^LINES_LOG2 lines of 128 bits with per-byte write
// enables and a registered read port.
// Ports:
//   clk, rst  - clock; rst clears only the read register, never the contents
//   addr      - line index
//   we        - 16 byte write enables (bit n writes byte n of the line)
//   wdata     - write line, byte n on bits [8n+7:8n]
//   re        - load the read register with the addressed line
//   rdata     - read register; holds its value when re is low
module dram_line_store
  import dram_line_pkg::*;
#(
  parameter int LINES_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LINES_LOG2-1:0]     addr,
  input  logic [LINE_BYTES-1:0]     we,
  input  logic [8*LINE_BYTES-1:0]   wdata,
  input  logic                      re,
  output logic [8*LINE_BYTES-1:0]   rdata
);

  logic [8*LINE_BYTES-1:0] mem [2**LINES_LOG2];
  logic [8*LINE_BYTES-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/dram_line_responder.sv
// Responder for the uncached DRAM line interface. Stands in for the SDRAM
// back end: waits INIT_CYCLES before reporting calibration, then accepts one
// read or write per busy handshake, completing each after LAT busy cycles.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   i_rd_en, i_wr_en       - command requests, held until o_busy is seen
//   i_addr                 - byte address (reads use [31:4], writes [31:2])
//   i_data, i_mask         - write lane data and active-low byte mask
//   o_data                 - last line read; changes only when a read completes
//   o_busy                 - high while initialising or executing a command
//   o_init_calib_complete  - high once initialisation has finished
//   o_err                  - sticky protocol error
module dram_line_responder
  import dram_line_pkg::*;
#(
  parameter int LINES_LOG2  = 10,
  parameter int LAT         = 4,
  parameter int INIT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rd_en,
  input  logic         i_wr_en,
  input  logic [31:0]  i_addr,
  input  logic [31:0]  i_data,
  input  logic [3:0]   i_mask,
  output logic [127:0] o_data,
  output logic         o_busy,
  output logic         o_init_calib_complete,
  output logic         o_err
);

  localparam int LINE_W = 8 * LINE_BYTES;

  state_e                state_q, state_d;
  logic [15:0]           init_cnt_q, init_cnt_d;
  logic [7:0]            lat_cnt_q, lat_cnt_d;
  logic                  calib_q, calib_d;
  logic                  err_q, err_d;
  // Latched command: addr holds {line index, lane}.
  logic [LINES_LOG2+1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            mask_q, mask_d;
  cmd_e                  cmd_q, cmd_d;

  logic                  store_re;
  logic [LINE_BYTES-1:0] store_we;
  logic [LINE_W-1:0]     store_rdata;
  logic                  req;
  logic                  unused_addr;

  assign req = i_rd_en | i_wr_en;
  // Address bits above the store wrap; the byte offset inside a lane is unused.
  assign unused_addr = ^{i_addr[31:LINES_LOG2+4], i_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    calib_d    = calib_q;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    cmd_d      = cmd_q;
    store_re   = 1'b0;
    store_we   = '0;
    case (state_q)
      ST_INIT: begin
        if (req) err_d = 1'b1;
        // Counter loads INIT_CYCLES at reset; 0 and 1 both leave on the first edge.
        if (init_cnt_q <= 16'd1) begin
          state_d = ST_IDLE;
          calib_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q - 16'd1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          addr_d    = i_addr[LINES_LOG2+3:2];
          data_d    = i_data;
          mask_d    = i_mask;
          cmd_d     = i_rd_en ? CMD_RD : CMD_WR;
          lat_cnt_d = 8'(LAT);
          state_d   = ST_BUSY;
          if (i_rd_en && i_wr_en) err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (lat_cnt_q == 8'd1) begin
          state_d = ST_IDLE;
          if (cmd_q == CMD_RD) store_re = 1'b1;
          else                 store_we = lane_byte_en(addr_q[1:0], mask_q);
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 16'(INIT_CYCLES);
      lat_cnt_q  <= '0;
      calib_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      calib_q    <= calib_d;
      err_q      <= err_d;
    end
  end

  // Command payload needs no reset: it is only consumed in ST_BUSY.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    mask_q <= mask_d;
    cmd_q  <= cmd_d;
  end

  dram_line_store #(
    .LINES_LOG2(LINES_LOG2)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr_q[LINES_LOG2+1:2]),
    .we    (store_we),
    .wdata ({(LINE_BYTES / LANE_BYTES){data_q}}),
    .re    (store_re),
    .rdata (store_rdata)
  );

  assign o_data                = store_rdata;
  assign o_busy                = (state_q != ST_IDLE);
  assign o_init_calib_complete = calib_q;
  assign o_err                 = err_q;

endmodule

// File: doc/dram_line_responder.md
# dram_line_responder

Responder end of the uncached DRAM line interface driven by the unaligned-access DRAM front-end controller. Accepts single-pulse read/write commands using the busy handshake, returns 128-bit lines on reads, and commits 32-bit byte-masked writes into an on-chip line store after a programmable latency. Replaces the MIG/SDRAM back end in simulation and in on-chip-RAM builds, so the front-end controller runs unchanged against it.

## Interface
- LINES_LOG2, 10: line store depth is 2^LINES_LOG2 lines of 16 bytes.
- LAT, 4: busy cycles per command; legal range 1..255.
- INIT_CYCLES, 16: cycles after reset before calibration-complete; legal range 0..65535.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_rd_en  in  1  read request; held by requester until o_busy seen high.
- i_wr_en  in  1  write request; same rule.
- i_addr  in  32  byte address; reads use [31:4], writes use [31:2]; bits above the store are ignored (wrap).
- i_data  in  32  write data, lane-aligned (byte n of lane on bits [8n+7:8n]).
- i_mask  in  4  active-low byte enables for writes; 0 = write byte.
- o_data  out  128  read line; byte 0 of line on bits [7:0].
- o_busy  out  1  command in progress or not yet calibrated.
- o_init_calib_complete  out  1  store ready.
- o_err  out  1  sticky protocol-error flag.

## Operation
- States: INIT, IDLE, BUSY.
- INIT: o_busy=1, o_init_calib_complete=0; init counter counts INIT_CYCLES, then IDLE with o_init_calib_complete=1 (stays 1 until reset). INIT_CYCLES=0: IDLE on first edge after reset release.
- IDLE: o_busy=0. On edge with i_rd_en or i_wr_en high: latch address, data, mask, command; load latency counter with LAT; go BUSY.
- Both enables high in IDLE: read wins, write dropped, o_err set.
- Enable high while in INIT: ignored, o_err set. Enables while BUSY: ignored, no error (requester legally holds enable through the first busy cycle).
- BUSY: o_busy=1; counter decrements each edge; on the edge counter==1: read captures store line at latched [LINES_LOG2+3:4] into o_data; write updates lane latched[3:2] of line latched[LINES_LOG2+3:4], only bytes with mask bit 0; then IDLE.
- Mask 4'b1111 write: completes handshake, store unchanged.
- o_data changes only on read completion; holds across writes and idle.
- Reset mid-command: command aborted, uncommitted write lost, store contents otherwise preserved (store not reset).

## Timing
- Reset values: o_busy=1, o_data=0, o_init_calib_complete=0, o_err=0, state INIT.
- Accept at edge k: o_busy=1 for cycles k+1..k+LAT; o_busy=0 from k+LAT+1; o_data valid from k+LAT+1 for reads.
- Store update/read at edge k+LAT; read after write to same line sees the write (no bypass needed, strictly ordered).
- Next command accepted earliest at edge k+LAT+1 (back-to-back with no idle gap permitted).
- Latency counter width 8 bits; init counter 16 bits.

## Structure
- Package dram_line_pkg: LINE_BYTES=16, LANE_BYTES=4, state enum {INIT, IDLE, BUSY}, command enum {CMD_RD, CMD_WR}.
- Sub-module dram_line_store: 2^LINES_LOG2 x 128 synchronous RAM, one port, 16 byte-write enables, registered read; top builds byte enables as ~i_mask shifted by 4*lane.
- Top holds FSM, counters, latches, error flag.

## Test plan
- Reset, INIT_CYCLES=16: o_busy=1 and calib=0 for 16 cycles, then o_busy=0, calib=1; rd_en pulsed during INIT -> ignored, o_err=1.
- Write 0xDEADBEEF, mask 4'b0000, addr 0x104; then read 0x100 -> o_data[63:32]=0xDEADBEEF, o_busy high exactly LAT=4 cycles each.
- Write 0x000000AA, mask 4'b1110, addr 0x10C over existing 0x11223344 -> read 0x100 gives o_data[127:96]=0x112233AA.
- Read with addr 0x10C and 0x100: identical line returned (low nibble ignored); addr 1<<(LINES_LOG2+4) aliases line 0.
- rd_en and wr_en both high in IDLE -> read performed, store unchanged, o_err=1 and stays set until rst.
- rst asserted on second BUSY cycle of a write -> o_busy=1, calib=0, o_data=0 immediately; subsequent read shows old line data.
